comefa_bitserial_ctrl: RTL
==========================

COMEFA_BITSERIAL_CTRL -- requirements
Module: comefa_bitserial_ctrl

Interface
REQ-001 SHALL have parameter AWIDTH, default 9, width of the compute-RAM write address.
REQ-002 SHALL have parameter CMD_ADDR, default 9'h1FF, the compute-RAM command address.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin an operation; sampled only in IDLE.
REQ-006 SHALL have port op  input  2  operation: 00 ADD, 01 AND, 10 OR, 11 XOR.
REQ-007 SHALL have ports src1_base, src2_base, dst_base  input  7 each  LSB row of operand 1, operand 2 and destination.
REQ-008 SHALL have port nbits  input  7  operand width in bits, 0..127.
REQ-009 SHALL have port stall  input  1  when 1, no command issues and sequencing holds.
REQ-010 SHALL have port busy  output  1  high from the cycle after accepted start until done.
REQ-011 SHALL have port done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port cmd_we  output  1  compute-RAM write enable (drives we1).
REQ-013 SHALL have port cmd_addr  output  AWIDTH  constant CMD_ADDR (drives addr1).
REQ-014 SHALL have port cmd_data  output  40  command word (drives d1).

Function
REQ-015 SHALL latch op, all bases and nbits on an accepted start, ignoring input changes until done.
REQ-016 SHALL ignore start while busy.
REQ-017 SHALL implement states IDLE, CLR, RUN, CARRY, DONE.
REQ-018 IDLE->CLR on start with nbits!=0; IDLE->DONE on start with nbits==0, issuing no command.
REQ-019 CLR SHALL issue one command with c_rst=1, write_en=0, all other fields 0 except predicate=11, then go to RUN.
REQ-020 RUN SHALL issue nbits commands, bit index k=0..nbits-1, with src1=src1_base+k, src2=src2_base+k, dst=dst_base+k, each mod 128 (row wrap-around).
REQ-021 RUN commands: predicate=11, dummy=0, write_en=1, write_sel=01, port=0, m_rst=0, m_en=0.
REQ-022 RUN truth_table: ADD 0110, AND 1000, OR 1110, XOR 0110.
REQ-023 RUN c_en=1, c_rst=0 for ADD; c_en=0, c_rst=1 for AND/OR/XOR.
REQ-024 Command bit positions: predicate[39:38], dummy[37:33], write_en[32], write_sel[31:30], port[29], c_rst[28], c_en[27], m_rst[26], m_en[25], truth_table[24:21], dst[20:14], src2[13:7], src1[6:0].
REQ-025 After the last RUN command, SHALL go to CARRY if op==ADD and COMEFA_CARRY_OUT_EN is defined, else to DONE.
REQ-026 DONE SHALL assert done for exactly one cycle, deassert busy, and return to IDLE.
REQ-027 cmd_we, cmd_data and busy SHALL be registered; an accepted start in cycle T SHALL produce the first cmd_we=1 in cycle T+1.
REQ-028 cmd_we SHALL be 1 only in cycles issuing a command; cmd_data is 0 when cmd_we=0.
REQ-029 While stall=1, cmd_we=0 and state plus bit counter SHALL hold; the pending command issues on the first cycle with stall=0.
REQ-030 Commands SHALL issue back-to-back, one per cycle, when stall=0.

Reset
REQ-031 resetn=0 SHALL immediately force IDLE, busy=0, done=0, cmd_we=0, cmd_data=0, counter=0, including mid-operation; no command is issued after resetn deasserts until a new start.

Configuration
REQ-032 Macro COMEFA_CARRY_OUT_EN: when defined, ADD ends with CARRY, issuing one command with write_en=1, port=1, write_sel=01, c_en=0, c_rst=0, truth_table=0000, dst=(dst_base+nbits) mod 128, src1=src2=0, predicate=11.
REQ-033 Without COMEFA_CARRY_OUT_EN, no CARRY state exists and ADD issues exactly 1+nbits commands.

Verification
REQ-034 ADD, src1=0, src2=8, dst=16, nbits=8, no stall -> commands in cycles T+1..T+9 (plus carry write to row 24 at T+10 with macro); done at the following cycle; the RAM model gives rows 16..23 = A+B.
REQ-035 XOR, nbits=4, dst_base=126 -> dst rows 126, 127, 0, 1; each command has c_rst=1, c_en=0.
REQ-036 nbits=0 with start -> no cmd_we; done pulses in cycle T+2; busy is high for one cycle.
REQ-037 ADD nbits=4 with stall high for 3 cycles after the second RUN command -> cmd_we low for those cycles; bit indices continue at 2 with no skip or duplication; total command count unchanged.
REQ-038 resetn low during RUN bit 3 -> outputs are 0 at once; IDLE after release; start pulses while busy are ignored (no restart).

Source files
------------

// File: rtl/comefa_bitserial_ctrl.sv
// comefa_bitserial_ctrl
//   Sequences the bit-serial command stream for a CoMeFa compute RAM. One
//   accepted start produces a carry-clear command and then one command per
//   operand bit (ADD/AND/OR/XOR). Each command is written to the RAM's
//   command address on port 1.
//
// Configuration:
//   COMEFA_CARRY_OUT_EN - when defined, ADD ends with one extra command that
//                         stores the final carry at row dst_base+nbits.
//
// Ports:
//   clk, resetn        - clock and asynchronous active-low reset
//   start              - one-cycle request, sampled only while idle
//   op                 - 00 ADD, 01 AND, 10 OR, 11 XOR
//   src1_base, src2_base, dst_base - LSB rows of operands and destination
//   nbits              - operand width in bits (0 completes with no command)
//   stall              - holds sequencing and suppresses command issue
//   busy, done         - operation in progress / one-cycle completion pulse
//   cmd_we, cmd_addr, cmd_data - command write to the compute RAM (we1/addr1/d1)
module comefa_bitserial_ctrl #(
  parameter int                AWIDTH   = 9,
  parameter logic [AWIDTH-1:0] CMD_ADDR = 9'h1FF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [6:0]        src1_base,
  input  logic [6:0]        src2_base,
  input  logic [6:0]        dst_base,
  input  logic [6:0]        nbits,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              cmd_we,
  output logic [AWIDTH-1:0] cmd_addr,
  output logic [39:0]       cmd_data
);

`ifdef COMEFA_CARRY_OUT_EN
  typedef enum logic [2:0] {IDLE, CLR, RUN, CARRY, DONE} state_e;
`else
  typedef enum logic [2:0] {IDLE, CLR, RUN, DONE} state_e;
`endif

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;

  // Carry-clear command: only predicate and c_rst are set.
  localparam logic [39:0] CLR_CMD = {2'b11, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1,
                                     1'b0, 1'b0, 1'b0, 4'b0000, 21'd0};

  state_e      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [6:0]  src1_q, src1_d, src2_q, src2_d, dst_q, dst_d, nbits_q, nbits_d;
  logic        busy_q, busy_d, done_q, done_d, cmd_we_q, cmd_we_d;
  logic [39:0] cmd_data_q, cmd_data_d;

  // Per-bit compute command. ADD chains the carry latch; logic ops keep it
  // cleared so a stale carry never leaks into the result.
  function automatic logic [39:0] run_cmd(input logic [1:0] cop,
                                          input logic [6:0] d,
                                          input logic [6:0] s2,
                                          input logic [6:0] s1);
    logic [3:0] tt;
    logic       c_rst, c_en;
    case (cop)
      OP_AND:  tt = 4'b1000;
      OP_OR:   tt = 4'b1110;
      default: tt = 4'b0110;
    endcase
    c_en  = (cop == OP_ADD);
    c_rst = (cop != OP_ADD);
    return {2'b11, 5'd0, 1'b1, 2'b01, 1'b0, c_rst, c_en, 1'b0, 1'b0, tt,
            d, s2, s1};
  endfunction

  // Outputs are registered, so this block computes what the command port
  // shows in the next cycle. That lets a start accepted in one cycle put
  // the carry-clear command on the bus in the very next cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    dst_d      = dst_q;
    nbits_d    = nbits_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cmd_we_d   = 1'b0;
    cmd_data_d = 40'd0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          src1_d  = src1_base;
          src2_d  = src2_base;
          dst_d   = dst_base;
          nbits_d = nbits;
          cnt_d   = 7'd0;
          busy_d  = 1'b1;
          if (nbits == 7'd0) begin
            state_d = DONE;
          end else if (stall) begin
            state_d = CLR;
          end else begin
            cmd_we_d   = 1'b1;
            cmd_data_d = CLR_CMD;
            state_d    = RUN;
          end
        end
      end
      CLR: begin
        if (!stall) begin
          cmd_we_d   = 1'b1;
          cmd_data_d = CLR_CMD;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (!stall) begin
          // 7-bit row sums wrap naturally at 128.
          cmd_we_d   = 1'b1;
          cmd_data_d = run_cmd(op_q, dst_q + cnt_q, src2_q + cnt_q,
                               src1_q + cnt_q);
          if (cnt_q == nbits_q - 7'd1) begin
            cnt_d = 7'd0;
`ifdef COMEFA_CARRY_OUT_EN
            state_d = (op_q == OP_ADD) ? CARRY : DONE;
`else
            state_d = DONE;
`endif
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
`ifdef COMEFA_CARRY_OUT_EN
      CARRY: begin
        if (!stall) begin
          // port=1 writes the carry latch rather than the truth-table result.
          cmd_we_d   = 1'b1;
          cmd_data_d = {2'b11, 5'd0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0,
                        1'b0, 4'b0000, dst_q + nbits_q, 7'd0, 7'd0};
          state_d    = DONE;
        end
      end
`endif
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= 7'd0;
      op_q       <= 2'b00;
      src1_q     <= 7'd0;
      src2_q     <= 7'd0;
      dst_q      <= 7'd0;
      nbits_q    <= 7'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cmd_we_q   <= 1'b0;
      cmd_data_q <= 40'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      dst_q      <= dst_d;
      nbits_q    <= nbits_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cmd_we_q   <= cmd_we_d;
      cmd_data_q <= cmd_data_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign cmd_we   = cmd_we_q;
  assign cmd_data = cmd_data_q;
  assign cmd_addr = CMD_ADDR;

endmodule
